// File: rtl/ifu_if.sv
// ---------------------------------------------------------------------------
// ifu_if -- instruction-memory request/response bus between the fetch unit
// and the instruction memory.
//   req    : request valid (fetch unit -> memory)
//   addr   : byte address, 4-aligned (fetch unit -> memory)
//   gnt    : memory accepted the request this cycle
//   rvalid : response valid; responses return in request order
//   rdata  : response instruction word
// Modports: master = fetch unit side, slave = memory side.
// ---------------------------------------------------------------------------
interface ifu_if;
    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (output req, output addr, input gnt, input rvalid, input rdata);
    modport slave  (input req, input addr, output gnt, output rvalid, output rdata);
endinterface

// File: rtl/ifu.sv
// ---------------------------------------------------------------------------
// ifu -- instruction fetch unit.
// Generates sequential PCs, issues IM requests under a credit limit, buffers
// returned words in a small fetch queue and presents them to decode. Redirects
// flush the queue and discard in-flight (stale) responses.
// Optional feature macro: IFU_MISALIGN_CHK_EN (adds sticky o_misalign).
// Ports:
//   clk, rst           clock (rising edge), asynchronous active-low reset
//   i_stall            decode cannot accept; hold presented entry
//   i_redirect(_pc)    redirect from execute and its target
//   im                 IM bus (ifu_if.master)
//   o_pc/o_inst/o_valid presented entry (o_inst = NOP when !o_valid)
//   o_misalign         sticky misaligned-redirect flag (macro builds only)
// ---------------------------------------------------------------------------
module ifu #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned FQ_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_stall,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    ifu_if.master       im,
    output logic [31:0] o_pc,
    output logic [31:0] o_inst,
    output logic        o_valid
`ifdef IFU_MISALIGN_CHK_EN
    ,
    output logic        o_misalign
`endif
);

    localparam int unsigned CW = $clog2(FQ_DEPTH + 1);
    localparam int unsigned PW = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {BOOT, FETCH, DRAIN} state_e;

    state_e          state_q;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]   out_q, out_d;
    logic [CW-1:0]   drop_q, drop_d;
    logic [CW-1:0]   fq_cnt_q, fq_cnt_d;
    logic [PW-1:0]   fq_hd_q, fq_tl_q;
    logic [31:0]     fq_pc_q   [FQ_DEPTH];
    logic [31:0]     fq_inst_q [FQ_DEPTH];
    logic [PW-1:0]   tg_hd_q, tg_tl_q;
    logic [31:0]     tg_q      [FQ_DEPTH];

    logic [CW:0]     used;
    logic            req, fire, rsp, push, pop;
    logic [31:0]     redir_tgt;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FQ_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign redir_tgt = {i_redirect_pc[31:2], 2'b00};

`ifndef IFU_MISALIGN_CHK_EN
    logic unused_redir_lsb;
    assign unused_redir_lsb = ^i_redirect_pc[1:0];
`endif

    always_comb begin
        used   = {1'b0, out_q} + {1'b0, fq_cnt_q};
        req    = (state_q != BOOT) && !i_redirect && (used < (CW+1)'(FQ_DEPTH));
        fire   = req && im.gnt;
        rsp    = im.rvalid;
        push   = rsp && (drop_q == '0) && !i_redirect;
        pop    = (fq_cnt_q != '0) && !i_stall && !i_redirect;

        fetch_pc_d = fetch_pc_q;
        if (i_redirect)
            fetch_pc_d = redir_tgt;
        else if (fire)
            fetch_pc_d = fetch_pc_q + 32'd4;

        out_d = out_q + CW'(fire) - CW'(rsp);

        // out_q counts every in-flight request, stale ones included, so on a
        // redirect everything still in flight after this cycle becomes stale.
        drop_d = drop_q;
        if (i_redirect)
            drop_d = out_q - CW'(rsp);
        else if (rsp && (drop_q != '0))
            drop_d = drop_q - CW'(1);

        fq_cnt_d = i_redirect ? '0 : fq_cnt_q + CW'(push) - CW'(pop);
    end

    assign im.req  = req;
    assign im.addr = fetch_pc_q;
    assign o_valid = (fq_cnt_q != '0);
    assign o_pc    = fq_pc_q[fq_hd_q];
    assign o_inst  = o_valid ? fq_inst_q[fq_hd_q] : NOP;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= BOOT;
            fetch_pc_q <= RESET_PC;
            out_q      <= '0;
            drop_q     <= '0;
            fq_cnt_q   <= '0;
            fq_hd_q    <= '0;
            fq_tl_q    <= '0;
            tg_hd_q    <= '0;
            tg_tl_q    <= '0;
            for (int unsigned i = 0; i < FQ_DEPTH; i++) begin
                fq_pc_q[i]   <= RESET_PC;
                fq_inst_q[i] <= '0;
                tg_q[i]      <= '0;
            end
`ifdef IFU_MISALIGN_CHK_EN
            o_misalign <= 1'b0;
`endif
        end else begin
            fetch_pc_q <= fetch_pc_d;
            out_q      <= out_d;
            drop_q     <= drop_d;
            fq_cnt_q   <= fq_cnt_d;

            case (state_q)
                BOOT:    state_q <= FETCH;
                FETCH:   if (i_redirect && (drop_d != '0)) state_q <= DRAIN;
                DRAIN:   if (!i_redirect && (drop_d == '0)) state_q <= FETCH;
                default: state_q <= BOOT;
            endcase

            // PC tags follow requests in order; stale responses still consume theirs.
            if (fire) begin
                tg_q[tg_tl_q] <= fetch_pc_q;
                tg_tl_q       <= ptr_inc(tg_tl_q);
            end
            if (rsp)
                tg_hd_q <= ptr_inc(tg_hd_q);

            if (i_redirect) begin
                fq_hd_q <= '0;
                fq_tl_q <= '0;
            end else begin
                if (push) begin
                    fq_pc_q[fq_tl_q]   <= tg_q[tg_hd_q];
                    fq_inst_q[fq_tl_q] <= im.rdata;
                    fq_tl_q            <= ptr_inc(fq_tl_q);
                end
                if (pop)
                    fq_hd_q <= ptr_inc(fq_hd_q);
            end

`ifdef IFU_MISALIGN_CHK_EN
            if (i_redirect && (i_redirect_pc[1:0] != 2'b00))
                o_misalign <= 1'b1;
`endif
        end
    end

endmodule
